// File: rtl/bg_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bg_cmd_pkg
// Brief    : Field layout, FSM encoding and command decode for bg_cmd_writer.
// Revision : 1.0 - initial release
// ============================================================================
package bg_cmd_pkg;

    localparam int c_ADDR_W     = 17;
    localparam int c_RUN_W      = 5;
    localparam int c_DATA_W     = 8;
    localparam int c_DEPTH      = 76800;

    localparam int c_TOGGLE_BIT = 31;
    localparam int c_FILL_BIT   = 30;
    localparam int c_ADDR_LSB   = 13;
    localparam int c_LEN_LSB    = 8;
    localparam int c_COLOUR_LSB = 0;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_FILL = 2'd2;

    typedef struct packed {
        logic                fill;
        logic [c_ADDR_W-1:0] addr;
        logic [c_RUN_W-1:0]  len_m1;
        logic [c_DATA_W-1:0] colour;
    } cmd_t;

    // The toggle bit is handled separately by edge detection, so only [30:0] is decoded.
    function automatic cmd_t bg_cmd_decode(input logic [30:0] word);
        cmd_t c;
        c.fill   = word[c_FILL_BIT];
        c.addr   = word[c_ADDR_LSB +: c_ADDR_W];
        c.len_m1 = word[c_LEN_LSB +: c_RUN_W];
        c.colour = word[c_COLOUR_LSB +: c_DATA_W];
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bg_cmd_pending.sv
`default_nettype none
// ============================================================================
// Module   : bg_cmd_pending
// Brief    : One-deep holding slot for commands arriving while the writer is busy.
// Revision : 1.0 - initial release
// ============================================================================
import bg_cmd_pkg::*;

module bg_cmd_pending (
    input  logic clk,
    input  logic reset,
    input  logic i_push,
    input  logic i_pop,
    input  cmd_t i_cmd,
    output logic o_valid,
    output cmd_t o_cmd,
    output logic o_overflow
);

    logic r_valid;
    cmd_t r_cmd;
    logic r_overflow;

    // A push in the same cycle as a pop refills the slot instead of dropping.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid    <= 1'b0;
            r_cmd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (i_push && (!r_valid || i_pop)) begin
                r_valid <= 1'b1;
                r_cmd   <= i_cmd;
            end else if (i_pop) begin
                r_valid <= 1'b0;
            end
            if (i_push && r_valid && !i_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign o_valid    = r_valid;
    assign o_cmd      = r_cmd;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: rtl/bg_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module   : bg_cmd_writer
// Brief    : Turns toggle-flagged background PIO commands into framebuffer
//            pixel writes (single, run, full-screen fill).
//            Optional: BG_CMD_ADDR_CLIP_EN clips runs at the last pixel.
// Revision : 1.0 - initial release
// ============================================================================
import bg_cmd_pkg::*;

module bg_cmd_writer #(
    parameter int ADDR_W = c_ADDR_W,
    parameter int RUN_W  = c_RUN_W,
    parameter int DATA_W = c_DATA_W,
    parameter int DEPTH  = c_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       cmd_word,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              overflow
);

    localparam logic [ADDR_W-1:0] c_LAST    = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_DEPTH_A = ADDR_W'(DEPTH);

    logic              r_prev_toggle;
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [ADDR_W-1:0] r_remaining;
    logic [DATA_W-1:0] r_colour;
    logic              r_clip_ovf;

    cmd_t              w_new_cmd;
    cmd_t              w_pend_cmd;
    cmd_t              w_ld_cmd;
    logic              w_pend_valid;
    logic              w_pend_ovf;
    logic              w_detect;
    logic              w_idle;
    logic              w_accept;
    logic              w_last;
    logic              w_load_new;
    logic              w_load_pend;
    logic              w_load;
    logic              w_push;
    logic              w_ld_reject;
    logic [RUN_W-1:0]  w_ld_len;
    logic [ADDR_W-1:0] w_ld_addr;
    logic [ADDR_W-1:0] w_ld_rem;
    logic [ADDR_W-1:0] w_next_addr;

    assign w_detect  = cmd_word[c_TOGGLE_BIT] ^ r_prev_toggle;
    assign w_new_cmd = bg_cmd_decode(cmd_word[30:0]);
    assign w_idle    = (r_state == c_ST_IDLE);
    assign w_accept  = !w_idle && wr_ready;

`ifdef BG_CMD_ADDR_CLIP_EN
    assign w_last = w_accept && ((r_remaining == '0) || (r_cur_addr == c_LAST));
`else
    assign w_last = w_accept && (r_remaining == '0);
`endif

    // Pending has priority over a fresh detect; a simultaneous detect refills the slot.
    assign w_load_pend = w_pend_valid && (w_idle || w_last);
    assign w_load_new  = w_detect && w_idle && !w_pend_valid;
    assign w_load      = w_load_pend || w_load_new;
    assign w_push      = w_detect && !w_load_new;

    assign w_next_addr = (r_cur_addr == c_LAST) ? '0 : r_cur_addr + 1'b1;

    always_comb begin
        w_ld_cmd    = w_load_pend ? w_pend_cmd : w_new_cmd;
        w_ld_len    = w_ld_cmd.len_m1;
        w_ld_reject = 1'b0;
        w_ld_addr   = '0;
        w_ld_rem    = c_LAST;
        if (!w_ld_cmd.fill) begin
            w_ld_rem = ADDR_W'(w_ld_len);
`ifdef BG_CMD_ADDR_CLIP_EN
            w_ld_addr   = w_ld_cmd.addr;
            w_ld_reject = (w_ld_cmd.addr >= c_DEPTH_A);
`else
            // 2^ADDR_W < 2*DEPTH, so a single subtraction reduces any address.
            w_ld_addr = (w_ld_cmd.addr >= c_DEPTH_A) ? w_ld_cmd.addr - c_DEPTH_A
                                                     : w_ld_cmd.addr;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_toggle <= 1'b0;
            r_state       <= c_ST_IDLE;
            r_cur_addr    <= '0;
            r_remaining   <= '0;
            r_colour      <= '0;
            r_clip_ovf    <= 1'b0;
        end else begin
            if (w_detect) begin
                r_prev_toggle <= cmd_word[c_TOGGLE_BIT];
            end
            if (w_load) begin
                if (w_ld_reject) begin
                    r_state    <= c_ST_IDLE;
                    r_clip_ovf <= 1'b1;
                end else begin
                    r_state     <= w_ld_cmd.fill ? c_ST_FILL : c_ST_RUN;
                    r_cur_addr  <= w_ld_addr;
                    r_remaining <= w_ld_rem;
                    r_colour    <= w_ld_cmd.colour;
                end
            end else if (w_last) begin
                r_state <= c_ST_IDLE;
            end else if (w_accept) begin
                r_cur_addr  <= w_next_addr;
                r_remaining <= r_remaining - 1'b1;
            end
        end
    end

    bg_cmd_pending u_pending (
        .clk        (clk),
        .reset      (reset),
        .i_push     (w_push),
        .i_pop      (w_load_pend),
        .i_cmd      (w_new_cmd),
        .o_valid    (w_pend_valid),
        .o_cmd      (w_pend_cmd),
        .o_overflow (w_pend_ovf)
    );

    assign wr_en    = !w_idle;
    assign wr_addr  = r_cur_addr;
    assign wr_data  = r_colour;
    assign busy     = !w_idle || w_pend_valid;
    assign overflow = w_pend_ovf || r_clip_ovf;

endmodule
`default_nettype wire

// File: tb/tb_bg_cmd_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bg_cmd_writer
// Brief    : Directed self-checking bench for bg_cmd_writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bg_cmd_writer;

    localparam int DEPTH = 76800;

    logic        clk      = 1'b0;
    logic        reset    = 1'b1;
    logic [31:0] cmd_word = 32'h0;
    logic        wr_ready = 1'b1;
    logic        wr_en;
    logic [16:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int hold_err = 0;
    logic tog_en = 1'b0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } wr_t;
    wr_t wlog[$];

    logic prev_stall = 1'b0;
    int   prev_a = 0;
    int   prev_d = 0;

    bg_cmd_writer dut (
        .clk      (clk),
        .reset    (reset),
        .cmd_word (cmd_word),
        .wr_ready (wr_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        wr_ready = tog_en ? ~wr_ready : 1'b1;
    end

    // Record every accepted write and flag any drift of addr/data across a stall.
    always @(negedge clk) begin
        if (wr_en && wr_ready) wlog.push_back('{int'(wr_addr), int'(wr_data), cyc});
        if (prev_stall && (int'(wr_addr) != prev_a || int'(wr_data) != prev_d)) hold_err++;
        prev_stall = wr_en && !wr_ready;
        prev_a     = int'(wr_addr);
        prev_d     = int'(wr_data);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_seq(input string tag, input int start, input int base,
                             input int n, input int data);
        int errs = 0;
        for (int i = 0; i < n; i++) begin
            if (start + i >= wlog.size()) errs++;
            else if (wlog[start+i].addr != (base + i) % DEPTH || wlog[start+i].data != data) errs++;
        end
        chk(tag, errs, 0);
    endtask

    task automatic issue(input logic [31:0] w);
        @(posedge clk);
        #1;
        cmd_word = w;
        @(negedge clk);
    endtask

    task automatic wait_idle(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                at = cyc;
                break;
            end
        end
        if (at < 0) chk("idle_timeout", 1, 0);
    endtask

    initial begin
        int t_idle;

        // Reset state
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);

        // Basic run of 11 pixels
        wlog.delete();
        issue(32'h8000_2A1F);
        chk("t1_busy_detect", busy, 0);
        chk("t1_wr_en_detect", wr_en, 0);
        @(negedge clk);
        chk("t1_busy_first", busy, 1);
        chk("t1_wr_en_first", wr_en, 1);
        chk("t1_addr_first", wr_addr, 1);
        chk("t1_data_first", wr_data, 8'h1F);
        wait_idle(100, t_idle);
        chk("t1_count", wlog.size(), 11);
        check_seq("t1_seq", 0, 1, 11, 8'h1F);
        if (wlog.size() > 0) chk("t1_busy_drop", t_idle, wlog[wlog.size()-1].cyc + 1);

        // Same run under back-pressure
        wlog.delete();
        hold_err = 0;
        tog_en = 1'b1;
        issue(32'h0000_2A1F);
        wait_idle(200, t_idle);
        tog_en = 1'b0;
        chk("t2_count", wlog.size(), 11);
        check_seq("t2_seq", 0, 1, 11, 8'h1F);
        chk("t2_hold", hold_err, 0);

        // Full fill, one pending run, one dropped command
        wlog.delete();
        issue(32'hC000_0003);
        repeat (3) @(posedge clk);
        issue(32'h000C_8255);
        repeat (3) @(posedge clk);
        issue(32'h8019_0077);
        @(negedge clk);
        chk("t3_overflow_set", overflow, 1);
        chk("t3_busy", busy, 1);
        wait_idle(80000, t_idle);
        chk("t3_count", wlog.size(), DEPTH + 3);
        check_seq("t3_fill_seq", 0, 0, DEPTH, 8'h03);
        check_seq("t3_pend_seq", DEPTH, 100, 3, 8'h55);
        if (wlog.size() > DEPTH) chk("t3_back2back", wlog[DEPTH].cyc, wlog[DEPTH-1].cyc + 1);
        if (wlog.size() > 0) chk("t3_busy_drop", t_idle, wlog[wlog.size()-1].cyc + 1);
        chk("t3_overflow_sticky", overflow, 1);

        // Run starting at the last pixel
        wlog.delete();
        issue(32'h257F_E244);
        wait_idle(100, t_idle);
`ifdef BG_CMD_ADDR_CLIP_EN
        chk("t4_count", wlog.size(), 1);
        check_seq("t4_seq", 0, DEPTH - 1, 1, 8'h44);
`else
        chk("t4_count", wlog.size(), 3);
        check_seq("t4_seq", 0, DEPTH - 1, 3, 8'h44);
`endif

        // Out-of-range start address (76805)
        wlog.delete();
        issue(32'hA580_A066);
        wait_idle(100, t_idle);
`ifdef BG_CMD_ADDR_CLIP_EN
        chk("t4b_count", wlog.size(), 0);
`else
        chk("t4b_count", wlog.size(), 1);
        check_seq("t4b_seq", 0, 5, 1, 8'h66);
`endif

        // Toggle back to 0, then start a toggle=1 run and reset it midway
        wlog.delete();
        issue(32'h0000_2A1F);
        wait_idle(100, t_idle);
        chk("t5a_count", wlog.size(), 11);
        issue(32'h8000_2A1F);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        wlog.delete();
        @(negedge clk);
        chk("t5_wr_en", wr_en, 0);
        chk("t5_busy", busy, 0);
        chk("t5_overflow", overflow, 0);
        @(negedge clk);
        chk("t5_redetect_busy", busy, 1);
        wait_idle(100, t_idle);
        chk("t5_count", wlog.size(), 11);
        check_seq("t5_seq", 0, 1, 11, 8'h1F);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
